// File: rtl/reg_file_stream.sv
// Register file with masked writes, write-first random read port and a
// wrap-around burst streamer that emits rows over a valid/ready handshake.
module reg_file_stream #(
    parameter  int DATA_WIDTH = 16,
    parameter  int MEM_LEN    = 16,
    parameter  int MEM_DEPTH  = 16,
    localparam int MEM_WIDTH  = DATA_WIDTH * MEM_LEN,
    localparam int AW         = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr_i,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [MEM_LEN-1:0]   wr_mask,
    input  logic [MEM_WIDTH-1:0] wr_data_i,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [MEM_WIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 burst_start_i,
    input  logic [AW-1:0]        burst_addr_i,
    input  logic [AW:0]          burst_len_i,
    output logic                 burst_busy_o,
    output logic [MEM_WIDTH-1:0] strm_data_o,
    output logic                 strm_valid_o,
    input  logic                 strm_ready_i,
    output logic                 strm_last_o
);

    // state  | meaning
    // IDLE   | no burst; waiting for a legal start request
    // RUN    | streaming rows from r_ptr until r_rem beats are loaded and the last is accepted
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [MEM_WIDTH-1:0] r_mem  [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] w_next [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] w_rd_view;
    logic [MEM_WIDTH-1:0] w_strm_view;

    logic [0:0]           r_state;
    logic [AW-1:0]        r_ptr;
    logic [AW:0]          r_rem;
    logic [MEM_WIDTH-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic [MEM_WIDTH-1:0] r_strm_data;
    logic                 r_strm_valid;
    logic                 r_strm_last;

    logic w_start_ok;
    logic w_load;
    logic w_accept;

    // Row contents after this edge; both read ports read through it (write-first).
    // Out-of-range write addresses match no row and are dropped.
    always_comb begin
        for (int r = 0; r < MEM_DEPTH; r++) begin
            w_next[r] = r_mem[r];
            if (clr_i) begin
                w_next[r] = '0;
            end else if (wr_en && (wr_addr == AW'(r))) begin
                for (int e = 0; e < MEM_LEN; e++) begin
                    if (wr_mask[e]) begin
                        w_next[r][e*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[e*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_view   = '0;
        w_strm_view = '0;
        for (int r = 0; r < MEM_DEPTH; r++) begin
            if (rd_addr == AW'(r)) w_rd_view = w_next[r];
            if (r_ptr == AW'(r))   w_strm_view = w_next[r];
        end
    end

    assign w_start_ok = burst_start_i && (burst_len_i != '0)
                        && (burst_len_i <= (AW+1)'(MEM_DEPTH))
                        && ((AW+1)'(burst_addr_i) < (AW+1)'(MEM_DEPTH));
    assign w_accept   = r_strm_valid && strm_ready_i;
    assign w_load     = (r_state == S_RUN) && (r_rem != '0) && (!r_strm_valid || strm_ready_i);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < MEM_DEPTH; r++) r_mem[r] <= '0;
        end else begin
            for (int r = 0; r < MEM_DEPTH; r++) r_mem[r] <= w_next[r];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_rem        <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_strm_data  <= '0;
            r_strm_valid <= 1'b0;
            r_strm_last  <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= w_rd_view;

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_ptr   <= burst_addr_i;
                        r_rem   <= burst_len_i;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_load) begin
                        r_strm_data  <= w_strm_view;
                        r_strm_valid <= 1'b1;
                        r_strm_last  <= (r_rem == (AW+1)'(1));
                        r_ptr        <= (r_ptr == AW'(MEM_DEPTH-1)) ? '0 : r_ptr + 1'b1;
                        r_rem        <= r_rem - 1'b1;
                    end else if (w_accept) begin
                        r_strm_valid <= 1'b0;
                        r_strm_last  <= 1'b0;
                    end
                    if (w_accept && r_strm_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data_o    = r_rd_data;
    assign rd_valid_o   = r_rd_valid;
    assign strm_data_o  = r_strm_data;
    assign strm_valid_o = r_strm_valid;
    assign strm_last_o  = r_strm_last;
    assign burst_busy_o = (r_state == S_RUN);

endmodule

// File: tb/tb_reg_file_stream.sv
// Directed bench for reg_file_stream: a row-array model with a beat queue
// checks every cycle, plus literal expectations on the test-plan scenarios.
module tb_reg_file_stream;

    localparam int DW = 16;
    localparam int ML = 16;
    localparam int MD = 16;
    localparam int MW = DW * ML;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clr_i;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [ML-1:0] wr_mask;
    logic [MW-1:0] wr_data_i;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [MW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          burst_start_i;
    logic [AW-1:0] burst_addr_i;
    logic [AW:0]   burst_len_i;
    logic          burst_busy_o;
    logic [MW-1:0] strm_data_o;
    logic          strm_valid_o;
    logic          strm_ready_i;
    logic          strm_last_o;

    reg_file_stream #(.DATA_WIDTH(DW), .MEM_LEN(ML), .MEM_DEPTH(MD)) dut (
        .clk(clk), .rstn(rstn), .clr_i(clr_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data_i(wr_data_i),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .burst_start_i(burst_start_i), .burst_addr_i(burst_addr_i), .burst_len_i(burst_len_i),
        .burst_busy_o(burst_busy_o), .strm_data_o(strm_data_o), .strm_valid_o(strm_valid_o),
        .strm_ready_i(strm_ready_i), .strm_last_o(strm_last_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model state
    logic [MW-1:0] m_mem [MD];
    logic [MW-1:0] m_rd_data;
    logic          m_rd_valid;
    bit            m_busy;
    bit            m_rst;
    logic [MW-1:0] m_q [$];
    int            m_beats;
    bit            m_stall;
    logic [MW-1:0] m_stall_data;
    logic          m_stall_last;

    always @(posedge clk) begin
        logic [MW-1:0] mm [MD];
        logic [MW-1:0] exp_row;
        if (!rstn) begin
            for (int r = 0; r < MD; r++) m_mem[r] = '0;
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_busy     = 1'b0;
            m_rst      = 1'b1;
            m_stall    = 1'b0;
            m_q.delete();
        end else begin
            m_rst = 1'b0;
            for (int r = 0; r < MD; r++) mm[r] = m_mem[r];
            if (clr_i) begin
                for (int r = 0; r < MD; r++) mm[r] = '0;
            end else if (wr_en && int'(wr_addr) < MD) begin
                for (int e = 0; e < ML; e++)
                    if (wr_mask[e]) mm[wr_addr][e*DW +: DW] = wr_data_i[e*DW +: DW];
            end
            m_rd_valid = rd_en;
            if (rd_en) m_rd_data = (int'(rd_addr) < MD) ? mm[rd_addr] : '0;

            m_stall      = strm_valid_o && !strm_ready_i;
            m_stall_data = strm_data_o;
            m_stall_last = strm_last_o;
            if (chk_en && strm_valid_o && strm_ready_i) begin
                m_beats++;
                if (m_q.size() == 0) begin
                    chk("beat_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_row = m_q.pop_front();
                    chk("beat_data", strm_data_o, exp_row);
                    chk("beat_last", strm_last_o, m_q.size() == 0);
                    if (m_q.size() == 0) m_busy = 1'b0;
                end
            end
            if (!m_busy && burst_start_i && burst_len_i >= 1 && burst_len_i <= MD
                && int'(burst_addr_i) < MD) begin
                for (int k = 0; k < int'(burst_len_i); k++)
                    m_q.push_back(mm[(int'(burst_addr_i) + k) % MD]);
                m_busy = 1'b1;
            end
            for (int r = 0; r < MD; r++) m_mem[r] = mm[r];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", rd_valid_o, m_rd_valid);
            chk("rd_data", rd_data_o, m_rd_data);
            chk("busy", burst_busy_o, m_busy);
            chk("valid_without_burst", strm_valid_o && !m_busy, 1'b0);
            if (m_stall) begin
                chk("stall_data", strm_data_o, m_stall_data);
                chk("stall_last", strm_last_o, m_stall_last);
            end
            if (m_rst) begin
                chk("rst_strm_valid", strm_valid_o, 1'b0);
                chk("rst_strm_last", strm_last_o, 1'b0);
                chk("rst_strm_data", strm_data_o, '0);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [ML-1:0] m, input logic [MW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_mask = m; wr_data_i = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic start(input int a, input int len);
        burst_start_i = 1'b1; burst_addr_i = AW'(a); burst_len_i = (AW+1)'(len);
        cyc();
        burst_start_i = 1'b0;
    endtask

    function automatic logic [MW-1:0] rowv(input logic [DW-1:0] v);
        return {ML{v}};
    endfunction

    initial begin
        int b0;
        int seq [4];
        logic [15:0] v;
        rstn = 1'b0; clr_i = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data_i = '0;
        rd_en = 1'b0; rd_addr = '0; burst_start_i = 1'b0; burst_addr_i = '0; burst_len_i = '0;
        strm_ready_i = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        chk("reset_rd_data", rd_data_o, '0);
        chk("reset_busy", burst_busy_o, 1'b0);
        rstn = 1'b1;
        cyc();

        // Masked write then read
        wr(3, 16'hFFFF, rowv(16'hAAAA));
        wr(3, 16'h000F, rowv(16'h1234));
        rd_en = 1'b1; rd_addr = 4'd3;
        cyc();
        rd_en = 1'b0;
        chk("mask_rd_valid", rd_valid_o, 1'b1);
        chk("mask_rd_data", rd_data_o, {{12{16'hAAAA}}, {4{16'h1234}}});
        cyc();
        chk("mask_rd_valid_drop", rd_valid_o, 1'b0);

        // Write-first bypass, then with clear
        wr_en = 1'b1; wr_addr = 4'd5; wr_mask = 16'hFFFF; wr_data_i = rowv(16'h0055);
        rd_en = 1'b1; rd_addr = 4'd5;
        cyc();
        chk("bypass_data", rd_data_o, rowv(16'h0055));
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0; wr_en = 1'b0;
        chk("bypass_clr_data", rd_data_o, '0);
        rd_addr = 4'd3;
        cyc();
        rd_en = 1'b0;
        chk("clr_row3", rd_data_o, '0);

        // Wrap-around burst with ready held high
        for (int r = 0; r < MD; r++) begin
            v = 16'(r);
            wr(r, 16'hFFFF, rowv(v));
        end
        strm_ready_i = 1'b1;
        b0 = m_beats;
        start(14, 4);
        chk("wrap_busy_t1", burst_busy_o, 1'b1);
        chk("wrap_valid_t1", strm_valid_o, 1'b0);
        seq = '{14, 15, 0, 1};
        for (int i = 0; i < 4; i++) begin
            cyc();
            v = 16'(seq[i]);
            chk("wrap_valid", strm_valid_o, 1'b1);
            chk("wrap_data", strm_data_o, rowv(v));
            chk("wrap_last", strm_last_o, i == 3);
        end
        cyc();
        chk("wrap_busy_end", burst_busy_o, 1'b0);
        chk("wrap_beats", m_beats - b0, 4);

        // Backpressure: ready pattern 0,0,1,0,1,1 from the first valid beat
        strm_ready_i = 1'b0;
        b0 = m_beats;
        start(2, 3);
        cyc();
        chk("bp_first", strm_data_o, rowv(16'd2));
        strm_ready_i = 1'b0; cyc();
        strm_ready_i = 1'b0; cyc();
        chk("bp_hold", strm_data_o, rowv(16'd2));
        strm_ready_i = 1'b1; cyc();
        strm_ready_i = 1'b0; cyc();
        chk("bp_hold2", strm_data_o, rowv(16'd3));
        strm_ready_i = 1'b1; cyc();
        chk("bp_lastbeat", strm_last_o, 1'b1);
        chk("bp_lastdata", strm_data_o, rowv(16'd4));
        strm_ready_i = 1'b1; cyc();
        chk("bp_beats", m_beats - b0, 3);
        chk("bp_busy_end", burst_busy_o, 1'b0);

        // Illegal starts
        b0 = m_beats;
        start(0, 0);
        chk("len0_busy", burst_busy_o, 1'b0);
        start(0, 17);
        chk("len17_busy", burst_busy_o, 1'b0);
        cyc();
        chk("illegal_no_valid", strm_valid_o, 1'b0);
        start(0, 2);
        start(5, 4);
        repeat (4) cyc();
        chk("busy_start_beats", m_beats - b0, 2);
        chk("busy_start_idle", burst_busy_o, 1'b0);

        // Reset during beat 2 of an 8-row burst
        b0 = m_beats;
        start(0, 8);
        cyc(); cyc();
        chk("mid_beat2", strm_data_o, rowv(16'd1));
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        chk("rst_valid", strm_valid_o, 1'b0);
        chk("rst_busy", burst_busy_o, 1'b0);
        cyc();
        chk("rst_no_beats", strm_valid_o, 1'b0);
        rd_en = 1'b1; rd_addr = 4'd5;
        cyc();
        rd_en = 1'b0;
        chk("rst_mem_row5", rd_data_o, '0);
        chk("rst_partial_beats", m_beats - b0, 1);
        wr(3, 16'hFFFF, rowv(16'h0777));
        wr(4, 16'hFFFF, rowv(16'h0888));
        start(3, 2);
        cyc();
        chk("fresh_b0", strm_data_o, rowv(16'h0777));
        cyc();
        chk("fresh_b1", strm_data_o, rowv(16'h0888));
        chk("fresh_last", strm_last_o, 1'b1);
        cyc();
        chk("fresh_idle", burst_busy_o, 1'b0);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file_stream.md
Name: reg_file_stream

Overview:
- Parametrised successor register file: MEM_DEPTH rows, each MEM_LEN elements of DATA_WIDTH bits.
- Adds a per-element write mask, simultaneous read/write with write-first bypass, and a synchronous clear.
- Adds a second, streaming read port: a burst engine walks consecutive rows with wrap-around and emits them over a valid/ready handshake.
- Feeds systolic-array row loaders; the random read port stays available for control/debug reads.

Parameters:
- DATA_WIDTH, 16, element width in bits.
- MEM_LEN, 16, elements per row. Row width MEM_WIDTH = DATA_WIDTH*MEM_LEN (localparam).
- MEM_DEPTH, 16, number of rows, >=2, need not be a power of 2. AW = $clog2(MEM_DEPTH) (localparam).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- clr_i  in  1  synchronous clear of all rows to 0.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write row.
- wr_mask  in  MEM_LEN  per-element write enable; bit e covers bits [e*DATA_WIDTH +: DATA_WIDTH].
- wr_data_i  in  MEM_WIDTH  write data.
- rd_en  in  1  random read strobe.
- rd_addr  in  AW  random read row.
- rd_data_o  out  MEM_WIDTH  random read data, registered.
- rd_valid_o  out  1  one-cycle pulse when rd_data_o updates.
- burst_start_i  in  1  start stream burst.
- burst_addr_i  in  AW  first row of burst.
- burst_len_i  in  AW+1  number of rows to stream.
- burst_busy_o  out  1  high while the burst FSM is in RUN.
- strm_data_o  out  MEM_WIDTH  streamed row.
- strm_valid_o  out  1  stream data valid.
- strm_ready_i  in  1  downstream ready.
- strm_last_o  out  1  marks final row of the burst; qualified by strm_valid_o.

Behaviour:
- Reset (rstn=0 at an edge):
  - all rows 0; rd_data_o=0, rd_valid_o=0; strm_data_o=0, strm_valid_o=0, strm_last_o=0, burst_busy_o=0; FSM to IDLE.
  - Reset mid-burst aborts the burst; no further beats.
- Write:
  - On wr_en, for each e with wr_mask[e]=1, mem[wr_addr][e] <= wr_data_i slice. Masked-off elements are unchanged.
  - wr_addr >= MEM_DEPTH: write ignored.
  - wr_mask all zero: no change.
- Clear: clr_i zeroes every row at the edge and has priority over a same-cycle write. It does not change the FSM or registered outputs.
- Merged view: the row contents as they will be after this cycle's write/clear. Used by both read ports (write-first bypass).
- Random read:
  - rd_en in cycle t gives rd_data_o = merged view of mem[rd_addr] and rd_valid_o=1 in cycle t+1.
  - Without rd_en: rd_valid_o=0 and rd_data_o holds.
  - rd_addr >= MEM_DEPTH returns 0, with valid still pulsed.
  - Reads and writes are fully concurrent. There is no wr/rd priority.
- Burst FSM, states IDLE and RUN. Internal ptr (AW bits) and remaining count rem (AW+1 bits).
  - IDLE: burst_start_i with 1 <= burst_len_i <= MEM_DEPTH and burst_addr_i < MEM_DEPTH sets ptr=burst_addr_i, rem=burst_len_i, goes to RUN. Any other start request is ignored.
  - RUN: burst_start_i is ignored.
  - Load condition: rem!=0 and (strm_valid_o=0 or strm_ready_i=1). On load, at the edge:
    - strm_data_o <= merged view of mem[ptr]; strm_valid_o <= 1; strm_last_o <= (rem==1);
    - ptr <= (ptr==MEM_DEPTH-1) ? 0 : ptr+1; rem <= rem-1.
  - Accepted beat = strm_valid_o and strm_ready_i.
    - Accepted beat with no load: strm_valid_o <= 0, strm_last_o <= 0.
    - Accepted beat with strm_last_o=1: FSM to IDLE.
  - While strm_valid_o=1 and strm_ready_i=0, strm_data_o and strm_last_o hold stable.
- Latency and throughput:
  - Start sampled in cycle t: RUN in t+1, first beat valid in t+2.
  - With ready held high, one row per cycle; the last beat is accepted in cycle t+1+len.
  - A new start is accepted no earlier than the cycle after the last acceptance.
- burst_busy_o = (state==RUN).
- Writes or clears during a burst are seen by rows not yet loaded. Already-loaded beats are unaffected.

Test Plan:
- Masked write: write row 3 all 0xAAAA, then row 3 mask=0x000F data all 0x1234; rd_en row 3 -> elements 0-3 = 0x1234, elements 4-15 = 0xAAAA; rd_valid_o pulses exactly one cycle after rd_en.
- Bypass: same cycle wr_en row 5 all 0x0055 full mask and rd_en row 5 -> next-cycle rd_data_o all 0x0055. Repeat with clr_i also high -> all 0.
- Burst wrap: rows preloaded with value = row index; burst_addr=14, len=4, ready high -> beats 14,15,0,1 on consecutive cycles starting start+2; last only on row 1; burst_busy_o drops the cycle after the last beat.
- Backpressure: len=3, strm_ready_i toggled 0,0,1,0,1,1 -> data/last stable while stalled; rows delivered in order with none dropped or duplicated.
- Illegal start: len=0, len=17, and a start while busy -> no state change, no beats.
- Reset mid-burst: rstn low during beat 2 of an 8-row burst -> all outputs 0, FSM IDLE, memory 0 on readback; a fresh burst afterwards works normally.
